mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between a fetch and a data requester, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_w_en,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_w_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              is_read_q, is_read_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              can_grant, dm_wins, complete;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant_q = 1 when data won the most recent grant
    logic last_grant_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant_q <= 1'b0;
        else if (if_gnt || dm_gnt)
            last_grant_q <= dm_gnt;
    end
    assign dm_wins = dm_req && (!if_req || !last_grant_q);
`else
    assign dm_wins = dm_req;
`endif

    // Grants are gated by rst_n so nothing is issued while reset is held.
    assign can_grant = (state_q == IDLE) && rst_n;
    assign complete  = (state_q == BUSY) && (cnt_q == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            owner_q    <= 1'b0;
            is_read_q  <= 1'b0;
            mem_addr_q <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            is_read_q  <= is_read_d;
            mem_addr_q <= mem_addr;
            if_rdata_q <= if_rdata;
            dm_rdata_q <= dm_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        is_read_d = is_read_q;
        case (state_q)
            IDLE: begin
                if (if_gnt || dm_gnt) begin
                    state_d   = BUSY;
                    cnt_d     = LAT;
                    owner_d   = dm_gnt;
                    is_read_d = if_gnt || (dm_w_en == 4'b0000);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dm_gnt    = can_grant && dm_wins;
        if_gnt    = can_grant && if_req && !dm_wins;
        mem_req   = if_gnt || dm_gnt;
        mem_addr  = mem_addr_q;
        mem_w_en  = 4'b0000;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_w_en  = dm_w_en;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
        if_rvalid = complete && is_read_q && !owner_q;
        dm_rvalid = complete && is_read_q && owner_q;
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;
        busy      = (state_q == BUSY);
    end
endmodule
